// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA 640x480@60 timing constants, pixel bit layout and
// the capture handshake state type used by the pixel sink.
package vga_pkg;

    // Horizontal timing in pixel ticks
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FRONT  = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BACK   = 48;
    localparam int unsigned H_TOTAL  = 800;

    // Vertical timing in lines
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FRONT  = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BACK   = 33;
    localparam int unsigned V_TOTAL  = 525;

    // Producer pixel byte layout; bits [1:0] carry no colour
    localparam int unsigned R_MSB = 7;
    localparam int unsigned R_LSB = 6;
    localparam int unsigned G_MSB = 5;
    localparam int unsigned G_LSB = 4;
    localparam int unsigned B_MSB = 3;
    localparam int unsigned B_LSB = 2;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } rgb_t;

    // Producer capture handshake: idle/waiting for strobe, or acknowledging
    typedef enum logic {
        CAP_IDLE = 1'b0,
        CAP_ACK  = 1'b1
    } cap_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: synchronous pixel FIFO with push, pop, flush and occupancy count.
// Full/empty come from the registered count; flush wins over push and pop.
module pixel_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage write; a flushed push is dropped
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vga_pixel_sink.sv
// vga_pixel_sink: VGA timing generator fed by a strobe/ack pixel producer
// through a pixel FIFO. Outputs are registered one tick after the position.
module vga_pixel_sink
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned H_ACT      = H_ACTIVE,
    parameter int unsigned H_FP       = H_FRONT,
    parameter int unsigned H_SW       = H_SYNC,
    parameter int unsigned H_BP       = H_BACK,
    parameter int unsigned V_ACT      = V_ACTIVE,
    parameter int unsigned V_FP       = V_FRONT,
    parameter int unsigned V_SW       = V_SYNC,
    parameter int unsigned V_BP       = V_BACK
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  data_i,
    input  logic                        stb_i,
    output logic                        ack_i,
    output logic                        frame_sync,
    output logic                        hsync,
    output logic                        vsync,
    output logic                        de,
    output logic [1:0]                  r,
    output logic [1:0]                  g,
    output logic [1:0]                  b,
    output logic                        underflow,
    output logic [$clog2(FIFO_DEPTH):0] fill_level
);

    localparam int unsigned H_TOT = H_ACT + H_FP + H_SW + H_BP;
    localparam int unsigned V_TOT = V_ACT + V_FP + V_SW + V_BP;
    localparam int unsigned XW    = $clog2(H_TOT);
    localparam int unsigned YW    = $clog2(V_TOT);
    localparam int unsigned DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [XW-1:0] X_ACT    = XW'(H_ACT);
    localparam logic [XW-1:0] X_HS_LO  = XW'(H_ACT + H_FP);
    localparam logic [XW-1:0] X_HS_HI  = XW'(H_ACT + H_FP + H_SW - 1);
    localparam logic [XW-1:0] X_LAST   = XW'(H_TOT - 1);
    localparam logic [XW-1:0] X_ONE    = XW'(1);
    localparam logic [YW-1:0] Y_ACT    = YW'(V_ACT);
    localparam logic [YW-1:0] Y_VS_LO  = YW'(V_ACT + V_FP);
    localparam logic [YW-1:0] Y_VS_HI  = YW'(V_ACT + V_FP + V_SW - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_TOT - 1);
    localparam logic [YW-1:0] Y_ONE    = YW'(1);

    logic [DW-1:0] div;
    logic [XW-1:0] sx;
    logic [YW-1:0] sy;
    logic          tick;
    logic          in_active;
    logic          in_hsync;
    logic          in_vsync;
    logic          frame_end;
    logic          flush;
    logic          pop;
    logic          push;
    logic          fifo_full;
    logic          fifo_empty;
    rgb_t          pix_in;
    rgb_t          pix_head;
    cap_state_t    cap_state;
    cap_state_t    cap_next;
    logic          unused_lsbs;

    assign tick      = (div == DIV_LAST);
    assign in_active = (sx < X_ACT) && (sy < Y_ACT);
    assign in_hsync  = (sx >= X_HS_LO) && (sx <= X_HS_HI);
    assign in_vsync  = (sy >= Y_VS_LO) && (sy <= Y_VS_HI);
    assign frame_end = (sx == X_LAST) && (sy == Y_LAST);
    assign flush     = tick && frame_end;
    assign pop       = tick && in_active;
    assign ack_i     = (cap_state == CAP_ACK);

    assign pix_in      = '{r: data_i[R_MSB:R_LSB], g: data_i[G_MSB:G_LSB], b: data_i[B_MSB:B_LSB]};
    assign unused_lsbs = ^data_i[1:0];

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(rgb_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (pix_in),
        .rdata (pix_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fill_level)
    );

    // Pixel-clock divider: one tick per CLK_DIV system clocks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + DIV_ONE;
        end
    end

    // Raster position, advanced once per tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sx <= '0;
            sy <= '0;
        end else if (tick) begin
            if (sx == X_LAST) begin
                sx <= '0;
                sy <= (sy == Y_LAST) ? '0 : sy + Y_ONE;
            end else begin
                sx <= sx + X_ONE;
            end
        end
    end

    // Registered video outputs from the pre-increment position
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            de        <= 1'b0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            r         <= '0;
            g         <= '0;
            b         <= '0;
            underflow <= 1'b0;
        end else if (tick) begin
            de    <= in_active;
            hsync <= ~in_hsync;
            vsync <= ~in_vsync;
            if (in_active && !fifo_empty) begin
                r <= pix_head.r;
                g <= pix_head.g;
                b <= pix_head.b;
            end else begin
                r <= '0;
                g <= '0;
                b <= '0;
            end
            if (in_active && fifo_empty) begin
                underflow <= 1'b1;
            end
        end
    end

    // Frame boundary pulse, coincident with the FIFO flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_sync <= 1'b0;
        end else begin
            frame_sync <= flush;
        end
    end

    // Capture handshake state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_state <= CAP_IDLE;
        end else begin
            cap_state <= cap_next;
        end
    end

    // Capture decision: acknowledge cycle blocks a second capture of the same strobe.
    // A push during flush is still acknowledged; the FIFO drops its data.
    always_comb begin
        cap_next = cap_state;
        push     = 1'b0;
        case (cap_state)
            CAP_IDLE: begin
                if (stb_i && !fifo_full) begin
                    push     = 1'b1;
                    cap_next = CAP_ACK;
                end
            end
            CAP_ACK: begin
                cap_next = CAP_IDLE;
            end
            default: begin
                cap_next = CAP_IDLE;
            end
        endcase
    end

endmodule

// File: doc/vga_pixel_sink.md
VGA_PIXEL_SINK -- requirements
Module: vga_pixel_sink

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4; system clocks per pixel tick (100 MHz -> 25 MHz).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16; pixel FIFO entries, power of two.
REQ-003 SHALL have clk  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have data_i  input  8  pixel from the pixel-processing unit; [7:6]=R, [5:4]=G, [3:2]=B, [1:0] ignored.
REQ-006 SHALL have stb_i  input  1  producer strobe; held high until acknowledged.
REQ-007 SHALL have ack_i  output  1  one-cycle acknowledge of a captured pixel.
REQ-008 SHALL have frame_sync  output  1  one-cycle pulse to the producer's sync input.
REQ-009 SHALL have hsync, vsync  output  1 each  active-low VGA sync.
REQ-010 SHALL have de  output  1  active-video flag.
REQ-011 SHALL have r, g, b  output  2 each  pixel colour.
REQ-012 SHALL have underflow  output  1  sticky flag: active pixel requested from an empty FIFO.
REQ-013 SHALL have fill_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-014 SHALL generate tick one cycle in every CLK_DIV, using a divider counter wrapping at CLK_DIV-1.
REQ-015 SHALL keep sx (0..799) and sy (0..524), advancing only on tick; sx wraps 799->0 and increments sy; sy wraps 524->0.
REQ-016 SHALL register outputs on tick from the pre-increment sx/sy: de=(sx<640 && sy<480); hsync=0 iff 656<=sx<=751; vsync=0 iff 490<=sy<=491.
REQ-017 SHALL, on a tick with de-condition true, pop one FIFO entry onto r/g/b; if the FIFO is empty, drive r=g=b=0 and set underflow.
REQ-018 SHALL drive r=g=b=0 on ticks outside active video, with no pop.
REQ-019 SHALL capture data_i into the FIFO in a cycle where stb_i=1, ack_i=0 and fill_level<FIFO_DEPTH, and assert ack_i for exactly the following cycle.
REQ-020 SHALL hold ack_i low while the FIFO is full; stb_i stays pending and is not captured.
REQ-021 SHALL never capture in a cycle where ack_i=1, so one strobe yields exactly one entry.
REQ-022 SHALL evaluate full/empty on registered occupancy; simultaneous push and pop change fill_level by 0.
REQ-023 SHALL pulse frame_sync and flush the FIFO (fill_level=0) on the tick where sx=799 and sy=524.
REQ-024 SHALL give flush priority over a coincident push: the data is discarded, but ack_i is still issued.
REQ-025 SHALL keep underflow set until reset.
REQ-026 SHALL have a latency of one tick from counter position to registered output.

Reset
REQ-027 SHALL, while rst=0, force: ack_i=0, frame_sync=0, hsync=1, vsync=1, de=0, r=g=b=0, underflow=0, fill_level=0, sx=sy=0, divider=0.
REQ-028 SHALL, on reset asserted mid-frame or mid-handshake, discard FIFO contents and any pending capture; after release, the first tick is at sx=0, sy=0.

Structure
REQ-029 SHALL take timing constants (640/16/96/48, 480/10/2/33, totals 800/525) and RGB bit positions from shared package vga_pkg.
REQ-030 SHALL implement the FIFO as sub-module pixel_fifo (synchronous, with push, pop, flush and count).

Verification
REQ-031 SHALL check timing: after reset with no producer, hsync low for 96 ticks per 800; vsync low for lines 490-491; de high for 640x480 ticks per frame.
REQ-032 SHALL check handshake: producer holds stb_i=1 with data_i=8'hF0 -> exactly one ack_i pulse, fill_level=1, and the first active pixel shows r=3, g=3, b=0.
REQ-033 SHALL check backpressure: 16 pixels are pushed with the display idle during blanking, then a 17th stb_i -> ack_i stays 0 until the first active pop, then ack pulses once.
REQ-034 SHALL check underflow: with an empty FIFO at sx=0, sy=0 -> r=g=b=0 and underflow=1, and it stays 1 through the next frame.
REQ-035 SHALL check the frame boundary: a push coincides with the tick at sx=799, sy=524 -> frame_sync pulses once, fill_level=0, and ack_i still pulses.
REQ-036 SHALL check mid-frame reset: rst pulsed low at sx=300, sy=200 with fill_level=5 -> all outputs take reset values, and after release hsync/vsync restart from sx=0, sy=0.
